// File: rtl/led_arb_pkg.sv
// Shared types and helpers for the LED arbiter.
// Configuration macro LED_ARBITER_RR_EN selects round-robin picking (default: fixed priority).
package led_arb_pkg;

  localparam int LED_W   = 8;
  localparam int MAX_REQ = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    REARB = 2'd2
  } state_e;

  function automatic logic [MAX_REQ-1:0] onehot_idx(input int unsigned idx);
    return MAX_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/led_arb_pick.sv
// Combinational requester picker: fixed priority by default,
// round-robin from last_idx+1 when LED_ARBITER_RR_EN is defined.
module led_arb_pick
  import led_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] last_idx_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  assign valid_o = |req_i;

`ifdef LED_ARBITER_RR_EN
  logic [IDX_W-1:0] cand;

  // Scan offsets from far to near so the nearest requester after last_idx wins.
  always_comb begin
    idx_o = '0;
    cand  = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IDX_W'((int'(last_idx_i) + k) % NREQ);
      if (req_i[cand]) idx_o = cand;
    end
  end
`else
  logic unused_last;
  assign unused_last = ^last_idx_i;

  always_comb begin
    idx_o = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_i[k]) idx_o = IDX_W'(k);
    end
  end
`endif

endmodule

// File: rtl/led_arbiter.sv
// Non-preemptive LED arbiter with minimum dwell per grant and base pattern when idle.
// Configuration macro LED_ARBITER_RR_EN (see led_arb_pick) selects round-robin picking.
module led_arbiter
  import led_arb_pkg::*;
#(
  parameter int                NREQ        = 4,
  parameter int                HOLD_W      = 27,
  parameter logic [HOLD_W-1:0] HOLD_CYCLES = HOLD_W'(125000000)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NREQ-1:0]         req_i,
  input  logic [NREQ*LED_W-1:0]   data_i,
  input  logic [LED_W-1:0]        base_i,
  output logic [LED_W-1:0]        led_o,
  output logic [NREQ-1:0]         grant_o,
  output logic                    busy_o
);

  localparam int                IDX_W       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_CYCLES - HOLD_W'(1);

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_ctr_q, hold_ctr_d;
  logic [IDX_W-1:0]  last_idx_q, last_idx_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic              busy_q, busy_d;

  logic [LED_W-1:0]  data_arr [NREQ];
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_valid;
  logic              holder_req;
  logic [LED_W-1:0]  holder_data;

  for (genvar g = 0; g < NREQ; g++) begin : g_data
    assign data_arr[g] = data_i[g*LED_W +: LED_W];
  end

  // last_idx always names the current holder while in HOLD/REARB.
  assign holder_req  = req_i[last_idx_q];
  assign holder_data = data_arr[last_idx_q];

  led_arb_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i      (req_i),
    .last_idx_i (last_idx_q),
    .idx_o      (pick_idx),
    .valid_o    (pick_valid)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      hold_ctr_q <= '0;
      last_idx_q <= '0;
      led_q      <= '0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_ctr_q <= hold_ctr_d;
      last_idx_q <= last_idx_d;
      led_q      <= led_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_ctr_d = hold_ctr_q;
    last_idx_d = last_idx_q;
    unique case (state_q)
      IDLE, REARB: begin
        if (pick_valid) begin
          state_d    = HOLD;
          hold_ctr_d = HOLD_RELOAD;
          last_idx_d = pick_idx;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        // Release by the holder beats both dwell expiry and any new request.
        if (!holder_req) begin
          state_d = IDLE;
        end else if (hold_ctr_q != '0) begin
          hold_ctr_d = hold_ctr_q - HOLD_W'(1);
        end else begin
          state_d = REARB;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    led_d   = base_i;
    grant_d = '0;
    busy_d  = (state_d != IDLE);
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = NREQ'(onehot_idx(32'(pick_idx)));
          led_d   = data_arr[pick_idx];
        end
      end
      HOLD: begin
        if (holder_req) begin
          grant_d = grant_q;
          led_d   = holder_data;
        end
      end
      REARB: begin
        led_d = holder_data;
        if (pick_valid) grant_d = NREQ'(onehot_idx(32'(pick_idx)));
      end
      default: ;
    endcase
  end

  assign led_o   = led_q;
  assign grant_o = grant_q;
  assign busy_o  = busy_q;

endmodule
